// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
// Shared encodings for the elastic pipeline stage register.
//   - pipe_lvl_e: occupancy / state encoding reported on pipe_skid_reg.level.
//   - Stage field widths and the EX/MEM payload width and bubble value,
//     built from the exception, memory-op and register-address fields.
// Stages pack their own fields into the opaque payload; this package only
// provides the sizes and the bubble (NOP / DISABLE_) value.
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    // Occupancy of the stage register; doubles as the state encoding.
    typedef enum logic [1:0] {
        PIPE_LVL_EMPTY = 2'd0,
        PIPE_LVL_ONE   = 2'd1,
        PIPE_LVL_TWO   = 2'd2
    } pipe_lvl_e;

    // Existing core field widths.
    localparam int WORD_W     = 32;
    localparam int EXP_CODE_W = 4;
    localparam int MEM_OP_W   = 4;
    localparam int REG_ADDR_W = 5;

    // Existing core field encodings used for a bubble.
    localparam logic [EXP_CODE_W-1:0] EXP_NO_EXP    = '0;
    localparam logic [MEM_OP_W-1:0]   MEM_OP_NOP    = '0;
    localparam logic [REG_ADDR_W-1:0] REG_ADDR_ZERO = '0;
    localparam logic [WORD_W-1:0]     WORD_ZERO     = '0;
    localparam logic                  DISABLE_      = 1'b1;  // active-low enables

    // EX/MEM payload: {exp_code, pc, mem_op, rd_addr, gpr_we_, result}
    localparam int EX_MEM_PAYLOAD_W =
        EXP_CODE_W + WORD_W + MEM_OP_W + REG_ADDR_W + 1 + WORD_W;

    localparam logic [EX_MEM_PAYLOAD_W-1:0] EX_MEM_PAYLOAD_RST =
        {EXP_NO_EXP, WORD_ZERO, MEM_OP_NOP, REG_ADDR_ZERO, DISABLE_, WORD_ZERO};

endpackage : pipe_skid_reg_pkg

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Elastic pipeline register between core stages, valid/ready handshake on
// both sides, opaque DATA_W payload. Flush inserts a bubble carrying RESET_VAL.
//
// Build option (macro PIPE_SKID_EN):
//   defined   - main + skid slot; in_ready is a flop (level != 2), so
//               back-pressure never forms a combinational path across stages.
//   undefined - main slot only; in_ready = !out_valid | out_ready.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   flush      synchronous kill of all held entries (highest priority)
//   in_valid   upstream has a payload
//   in_data    upstream payload
//   in_ready   stage can accept this cycle
//   out_valid  downstream payload valid
//   out_data   downstream payload (main slot)
//   out_ready  downstream accepts this cycle
//   level      occupancy 0, 1 or 2
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        level
);

    pipe_lvl_e         level_q, level_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic              accept;
    logic              dequeue;

    assign out_valid = (level_q != PIPE_LVL_EMPTY);
    assign out_data  = main_q;
    assign level     = level_q;

    // A flush-cycle input is dropped even when in_ready is high.
    assign accept  = in_valid & in_ready & ~flush;
    assign dequeue = out_valid & out_ready;

`ifdef PIPE_SKID_EN

    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;

    assign in_ready = in_ready_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        level_d = level_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (level_q)
            PIPE_LVL_EMPTY: begin
                if (accept) begin
                    level_d = PIPE_LVL_ONE;
                    main_d  = in_data;
                end
            end
            PIPE_LVL_ONE: begin
                if (accept && !dequeue) begin
                    level_d = PIPE_LVL_TWO;
                    skid_d  = in_data;
                end else if (accept && dequeue) begin
                    main_d  = in_data;
                end else if (dequeue) begin
                    level_d = PIPE_LVL_EMPTY;
                end
            end
            PIPE_LVL_TWO: begin
                // in_ready is low here, so accept cannot fire.
                if (dequeue) begin
                    level_d = PIPE_LVL_ONE;
                    main_d  = skid_q;
                end
            end
            default: level_d = PIPE_LVL_EMPTY;
        endcase

        // A simultaneous dequeue is treated as taken downstream; the held
        // entries are killed either way.
        if (flush) begin
            level_d = PIPE_LVL_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the payload slots are reset (not left X) because out_data
            // must show RESET_VAL whenever the stage is empty after reset.
            level_q    <= PIPE_LVL_EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            level_q    <= level_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Registered from the next level so in_ready never sees out_ready
            // or flush combinationally.
            in_ready_q <= (level_d != PIPE_LVL_TWO);
        end
    end

`else

    // Single slot: can refill in the same cycle the held payload leaves.
    assign in_ready = ~out_valid | out_ready;

    always_comb begin
        level_d = level_q;
        main_d  = main_q;

        case (level_q)
            PIPE_LVL_EMPTY: begin
                if (accept) begin
                    level_d = PIPE_LVL_ONE;
                    main_d  = in_data;
                end
            end
            PIPE_LVL_ONE: begin
                // accept here implies dequeue (in_ready needs out_ready).
                if (accept) begin
                    main_d  = in_data;
                end else if (dequeue) begin
                    level_d = PIPE_LVL_EMPTY;
                end
            end
            default: level_d = PIPE_LVL_EMPTY;
        endcase

        if (flush) begin
            level_d = PIPE_LVL_EMPTY;
            main_d  = RESET_VAL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= PIPE_LVL_EMPTY;
            main_q  <= RESET_VAL;
        end else begin
            level_q <= level_d;
            main_q  <= main_d;
        end
    end

`endif

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Directed and random checks for pipe_skid_reg; expectations follow the
// PIPE_SKID_EN build option (macro PIPE_SKID_EN selects the skid variant).
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int         DATA_W = 8;
    localparam logic [7:0] RST_V  = 8'h5A;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [DATA_W-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [DATA_W-1:0] out_data;
    logic             out_ready;
    logic [1:0]       level;

    int errors = 0;
    int checks = 0;

    pipe_skid_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RST_V)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;
    bit         acc, deq, acc_prev;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  RST_V);
        check("rst_level",     level,     0);
        check("rst_in_ready",  in_ready,  1);
        @(negedge clk);
        reset = 1'b0;

        // ---- first transfer ----------------------------------------------
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data",  out_data,  8'h11);
        check("t1_level",     level,     1);
        check("t1_in_ready",  in_ready,  1);
        tick();
        check("t1_drain_valid", out_valid, 0);
        check("t1_drain_level", level,     0);

        // ---- back-pressure -----------------------------------------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1;
        tick();
        check("bp_a1_valid", out_valid, 1);
        check("bp_a1_data",  out_data,  8'hA1);
        check("bp_a1_level", level,     1);
        in_data = 8'hA2;
        #1;
        check("bp_rdy_one", in_ready, SKID ? 1 : 0);
        tick();
        check("bp_a2_data",  out_data, 8'hA1);
        check("bp_a2_level", level,    SKID ? 2 : 1);
        check("bp_a2_rdy",   in_ready, 0);
        // Skid build took A2 and now offers A3; single slot still offers A2.
        in_data = SKID ? 8'hA3 : 8'hA2;
        tick();
        check("bp_hold_data",  out_data, 8'hA1);
        check("bp_hold_level", level,    SKID ? 2 : 1);
        check("bp_hold_rdy",   in_ready, 0);
        out_ready = 1'b1;
        #1;
        // Registered in_ready must not follow out_ready in the skid build.
        check("bp_rdy_comb", in_ready, SKID ? 0 : 1);
        tick();
        check("bp_o2_valid", out_valid, 1);
        check("bp_o2_data",  out_data,  8'hA2);
        check("bp_o2_level", level,     1);
        check("bp_o2_rdy",   in_ready,  1);
        in_data = 8'hA3;
        tick();
        in_valid = 1'b0;
        check("bp_o3_valid", out_valid, 1);
        check("bp_o3_data",  out_data,  8'hA3);
        check("bp_o3_level", level,     1);
        tick();
        check("bp_end_valid", out_valid, 0);
        check("bp_end_level", level,     0);

        // ---- streaming 100 payloads ----------------------------------------
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            check("st_valid", out_valid, 1);
            check("st_data",  out_data,  i);
            check("st_level", level,     1);
        end
        in_valid = 1'b0;
        tick();
        check("st_end_level", level, 0);

        // ---- flush at full occupancy -------------------------------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hC1;
        tick();
        in_data = 8'hC2;
        tick();
        check("fl_pre_level", level, SKID ? 2 : 1);
        in_data = 8'hBB;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_valid",    out_valid, 0);
        check("fl_level",    level,     0);
        check("fl_data",     out_data,  RST_V);
        check("fl_in_ready", in_ready,  1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_bb_valid", out_valid, 0);
            check("fl_no_bb_data",  out_data,  RST_V);
        end

        // ---- flush with simultaneous dequeue -----------------------------
        in_valid = 1'b1; in_data = 8'hD1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check("fld_valid", out_valid, 0);
        check("fld_level", level,     0);
        check("fld_data",  out_data,  RST_V);

        // ---- asynchronous reset mid-cycle --------------------------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hE1;
        tick();
        in_data = 8'hE2;
        tick();
        in_valid = 1'b0;
        check("ar_pre_level", level, SKID ? 2 : 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid",    out_valid, 0);
        check("ar_in_ready", in_ready,  1);
        check("ar_level",    level,     0);
        check("ar_data",     out_data,  RST_V);
        @(negedge clk);
        reset = 1'b0;

        // ---- random valid/ready with scoreboard --------------------------
        acc_prev = 1'b1;
        in_valid = 1'b0;
        tick();
        for (int c = 0; c < 10000; c++) begin
            check("rnd_level", level, q.size());
            // Upstream holds an offered payload until it is taken.
            if (!(in_valid && !acc_prev)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom_range(0, 255));
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("rnd_in_ready", in_ready,
                  SKID ? (q.size() < 2) : (q.size() == 0 || out_ready));
            acc = in_valid && in_ready;
            deq = out_valid && out_ready;
            if (deq) begin
                if (q.size() > 0) begin
                    exp_d = q.pop_front();
                    check("rnd_data", out_data, exp_d);
                end else begin
                    check("rnd_spurious_valid", out_valid, 0);
                end
            end
            if (acc) q.push_back(in_data);
            acc_prev = acc;
            tick();
        end

        // Drain whatever is left.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) begin
                if (q.size() > 0) begin
                    exp_d = q.pop_front();
                    check("drain_data", out_data, exp_d);
                end else begin
                    check("drain_spurious_valid", out_valid, 0);
                end
            end
            tick();
        end
        check("drain_level", level, 0);
        check("drain_left",  q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_skid_reg

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register replacing the fixed stall/flush stage registers between core pipeline stages (ID/EX, EX/MEM, MEM/WB). It carries an opaque payload of configurable width under a valid/ready handshake. A 2-entry skid buffer registers the upstream ready so back-pressure never forms a combinational path across stages. Synchronous flush inserts a bubble with a configurable payload value.

## Interface
Parameters:
- DATA_W, 32: payload width in bits (packed stage fields: exception code, pc, mem op, rd addr, gpr_we_, result, ...).
- RESET_VAL, {DATA_W{1'b0}}: payload value driven after reset and flush. Encodes NOP / DISABLE_ fields.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries; highest priority.
- in_valid  in  1  upstream has a payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept this cycle.
- out_valid  out  1  downstream payload valid.
- out_data  out  DATA_W  downstream payload.
- out_ready  in  1  downstream accepts this cycle.
- level  out  2  occupancy: 0, 1 or 2.

## Operation
- Accept = in_valid & in_ready & !flush. Dequeue = out_valid & out_ready.
- Storage: main slot (drives out_data) and skid slot. State is encoded in level.
- EMPTY (level 0), in_ready=1:
  - accept -> ONE, main<=in_data.
- ONE (level 1), in_ready=1:
  - accept & !dequeue -> TWO, skid<=in_data.
  - accept & dequeue -> ONE, main<=in_data.
  - !accept & dequeue -> EMPTY.
- TWO (level 2), in_ready=0:
  - dequeue -> ONE, main<=skid.
  - in_valid is ignored.
- Flush: any state -> EMPTY. Main and skid <= RESET_VAL. out_valid=0. in_data presented in the flush cycle is dropped even if in_ready=1.
- Order is strictly FIFO. No payload is duplicated or lost except by flush.
- out_data holds stable while out_valid & !out_ready, unless flush occurs.
- out_data equals RESET_VAL whenever out_valid=0 after reset or flush.
- After a dequeue to EMPTY, out_data retains the last payload. The payload is don't-care for downstream, but the bench must not check it.

## Timing
- Reset values:
  - out_valid=0, out_data=RESET_VAL, level=0.
  - in_ready=1, and in_ready becomes 1 immediately when reset asserts.
  - Skid slot holds RESET_VAL.
- Latency: accept in cycle N -> out_valid=1 with that payload in cycle N+1.
- Throughput: 1 payload/cycle sustained while out_ready=1.
- in_ready is a flop output (registered as level!=2). It has no combinational dependence on out_ready or flush.
- Reset asserted mid-transfer clears both slots asynchronously. Held payloads are discarded.
- Simultaneous flush & out_ready: the dequeue is considered to have happened downstream. Internally the state still goes to EMPTY.

## Configuration
- Macro: PIPE_SKID_EN.
- Defined: 2-entry skid buffer as above; in_ready is registered.
- Undefined: single main slot only.
  - in_ready = !out_valid | out_ready, combinational.
  - TWO is unreachable and level never exceeds 1.
  - Latency, flush and reset behaviour are unchanged.

## Structure
- Shared defines file holds:
  - the level/state encodings (PIPE_LVL_EMPTY=2'd0, PIPE_LVL_ONE=2'd1, PIPE_LVL_TWO=2'd2);
  - the per-stage payload width and RESET_VAL constants (EX_MEM_PAYLOAD_W, EX_MEM_PAYLOAD_RST) built from the existing EXP/MEM_OP/REG_ADDR field widths.
- Packing and unpacking of stage fields is done by the instantiating stage, not inside this block.
- Single module; no sub-module. Slot update logic is too small to split.

## Test plan
- Reset, then in_valid=1, in_data=0x11, out_ready=1 -> next cycle out_valid=1, out_data=0x11, level=1, in_ready=1.
- Back-pressure: push 0xA1, 0xA2, 0xA3 on consecutive cycles with out_ready=0 -> level reaches 2 and in_ready=0 after 0xA2. 0xA3 is held upstream. Then raise out_ready -> outputs 0xA1, 0xA2, 0xA3 in order with no gaps.
- Streaming: 100 back-to-back payloads 0..99 with out_ready=1 -> 100 outputs in order, one per cycle, level stays 1.
- Flush with level=2 and in_valid=1 (0xBB) -> next cycle out_valid=0, level=0, out_data=RESET_VAL. 0xBB never appears on the output.
- Async reset asserted mid-cycle at level=2 -> out_valid=0, in_ready=1 immediately, without waiting for a clock edge.
- Random valid/ready stall (50% each, 10k cycles), with and without PIPE_SKID_EN -> scoreboard order preserved. in_ready never depends combinationally on out_ready when PIPE_SKID_EN is defined.
